// File: rtl/avst_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ Avalon-ST sources into one FIFO write port.
// Grants last up to MAX_BURST beats; per-requester saturating beat counters are exported.
module avst_rr_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arb_en,
  input  logic [NUM_REQ*WIDTH-1:0]     src_data,
  input  logic [NUM_REQ-1:0]           src_valid,
  output logic [NUM_REQ-1:0]           src_ready,
  output logic [WIDTH-1:0]             snk_data,
  output logic                         snk_valid,
  input  logic                         snk_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [NUM_REQ*CNT_W-1:0]     beat_total
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   last_grant_q;
  logic [BC_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]  total_q [NUM_REQ];

  logic              sel_valid;
  logic [WIDTH-1:0]  sel_data;
  logic              active;
  logic              xfer;

  // First requesting index after 'last', wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (req[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with rst keeps a mid-burst reset cycle from handshaking.
  assign active    = (state_q == StXfer) && rst;
  assign xfer      = active && sel_valid && snk_ready;
  assign snk_valid = active && sel_valid;
  assign snk_data  = sel_data;
  assign busy      = (state_q == StXfer);
  assign grant_id  = grant_q;

  always_comb begin
    src_ready  = '0;
    beat_total = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      src_ready[i]               = active && snk_ready && (grant_q == ID_W'(i));
      beat_total[i*CNT_W +: CNT_W] = total_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) total_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (xfer && (grant_q == ID_W'(i)) && (total_q[i] != CNT_MAX)) begin
          total_q[i] <= total_q[i] + 1'b1;
        end
      end
      case (state_q)
        StIdle: begin
          if (arb_en && |src_valid) begin
            grant_q    <= rr_pick(src_valid, last_grant_q);
            beat_cnt_q <= '0;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          if (!sel_valid) begin
            state_q      <= StIdle;
            last_grant_q <= grant_q;
          end else if (snk_ready) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q      <= StIdle;
              last_grant_q <= grant_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
